// File: rtl/control_luces.sv
// Run/stop light sequencer: debounced KEY_RUN toggles the FSM, which emits ENABLE ticks at a SPEED-selected rate.
// Optional single-step button when CONTROL_LUCES_STEP_EN is defined (adds port KEY_STEP).

module control_luces_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic key_n,
    output logic press
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Accept the new level; only a high-to-low change counts as a press.
            level_d = sync2_q;
            cnt_d   = '0;
            press_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;
endmodule

module control_luces #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned BASE_TICK       = 6250000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KEY_RUN,
`ifdef CONTROL_LUCES_STEP_EN
    input  logic       KEY_STEP,
`endif
    input  logic [1:0] SPEED,
    output logic       ENABLE,
    output logic       RUN
);
    typedef enum logic {S_STOP = 1'b0, S_RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [26:0] cnt_q, cnt_d;
    logic [26:0] term_q, term_d;
    logic        enable_q, enable_d;
    logic        run_q, run_d;
    logic        run_press;
    logic        step_press;
    logic [27:0] period_full;
    logic [26:0] term_new;

    control_luces_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_run (
        .CLK   (CLK),
        .RST   (RST),
        .key_n (KEY_RUN),
        .press (run_press)
    );

`ifdef CONTROL_LUCES_STEP_EN
    control_luces_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_step (
        .CLK   (CLK),
        .RST   (RST),
        .key_n (KEY_STEP),
        .press (step_press)
    );
`else
    assign step_press = 1'b0;
`endif

    // Period minus one held in 27 bits; 28-bit intermediate absorbs 2^24 << 3.
    assign period_full = 28'(BASE_TICK) << (2'd3 - SPEED);
    assign term_new    = 27'(period_full - 28'd1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        term_d   = term_q;
        enable_d = 1'b0;
        case (state_q)
            S_STOP: begin
                cnt_d    = '0;
                enable_d = step_press;
                if (run_press) begin
                    state_d = S_RUN;
                    term_d  = term_new;
                end
            end
            S_RUN: begin
                if (cnt_q == term_q) begin
                    enable_d = 1'b1;
                    cnt_d    = '0;
                    term_d   = term_new;
                end else begin
                    cnt_d = cnt_q + 27'd1;
                end
                if (run_press) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_STOP;
                cnt_d   = '0;
            end
        endcase
        run_d = (state_d == S_RUN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_STOP;
            cnt_q    <= '0;
            term_q   <= '0;
            enable_q <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            term_q   <= term_d;
            enable_q <= enable_d;
            run_q    <= run_d;
        end
    end

    assign ENABLE = enable_q;
    assign RUN    = run_q;
endmodule
